// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters (ALU, load) and the register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned N  = 32,
    parameter int unsigned AW = 5
);
    logic          a_valid;
    logic [AW-1:0] a_rd;
    logic [N-1:0]  a_data;
    logic          a_ready;

    logic          b_valid;
    logic [AW-1:0] b_rd;
    logic [N-1:0]  b_data;
    logic          b_ready;

    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [N-1:0]  rf_wdata;

    // Arbiter side
    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready,
        output rf_we, rf_rd, rf_wdata
    );

    // Requester / register-file side
    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready,
        input  rf_we, rf_rd, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B)
// write-back; registers the winning write, suppresses x0 writes, counts contention.
module regfile_wb_arbiter #(
    parameter int unsigned N  = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    regfile_wb_arbiter_if.slave    bus,
    output logic                   prio_b,
    output logic [CW-1:0]          conflict_cnt
);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

    prio_t         state;
    prio_t         state_next;
    logic          a_xfer;
    logic          b_xfer;
    logic          win_we;
    logic [AW-1:0] win_rd;
    logic [N-1:0]  win_data;

    // Readies depend only on hold, the other requester's valid and the priority flag
    assign bus.a_ready = !hold && (!bus.b_valid || (state == PRIO_A));
    assign bus.b_ready = !hold && (!bus.a_valid || (state == PRIO_B));

    assign a_xfer = bus.a_valid && bus.a_ready;
    assign b_xfer = bus.b_valid && bus.b_ready;
    assign prio_b = (state == PRIO_B);

    // Priority flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRIO_A;
        end else begin
            state <= state_next;
        end
    end

    // Next priority and winning payload selection
    always_comb begin
        state_next = state;
        win_we     = 1'b0;
        win_rd     = bus.a_rd;
        win_data   = bus.a_data;
        if (a_xfer) begin
            state_next = PRIO_B;
            win_we     = (bus.a_rd != '0);
        end else if (b_xfer) begin
            state_next = PRIO_A;
            win_we     = (bus.b_rd != '0);
            win_rd     = bus.b_rd;
            win_data   = bus.b_data;
        end
    end

    // Register-file write port; address/data hold their last value when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rf_we    <= 1'b0;
            bus.rf_rd    <= '0;
            bus.rf_wdata <= '0;
        end else begin
            bus.rf_we <= win_we;
            if (a_xfer || b_xfer) begin
                bus.rf_rd    <= win_rd;
                bus.rf_wdata <= win_data;
            end
        end
    end

    // Saturating count of cycles where both requesters compete
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (bus.a_valid && bus.b_valid && !hold && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    localparam int unsigned N  = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          hold;
    logic          prio_b;
    logic [CW-1:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter_if #(.N(N), .AW(AW)) bus ();

    regfile_wb_arbiter #(.N(N), .AW(AW), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .bus          (bus),
        .prio_b       (prio_b),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hold        = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_rd    = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_rd    = '0;
        bus.b_data  = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", bus.rf_we); end
        checks++; if (bus.rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rf_rd got %0d exp 0", bus.rf_rd); end
        checks++; if (bus.rf_wdata !== 32'h0) begin errors++; $display("FAIL reset_rf_wdata got %h exp 0", bus.rf_wdata); end
        checks++; if (prio_b !== 1'b0) begin errors++; $display("FAIL reset_prio_b got %b exp 0", prio_b); end
        checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", conflict_cnt); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b exp 1", bus.a_ready); end
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready got %b exp 1", bus.b_ready); end
    endtask

    task automatic test_a_only();
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd5;
        bus.a_data  = 32'h1234;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready got %b exp 1", bus.a_ready); end
        tick();
        bus.a_valid = 1'b0;
        checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL a_only_we got %b exp 1", bus.rf_we); end
        checks++; if (bus.rf_rd !== 5'd5) begin errors++; $display("FAIL a_only_rd got %0d exp 5", bus.rf_rd); end
        checks++; if (bus.rf_wdata !== 32'h1234) begin errors++; $display("FAIL a_only_data got %h exp 1234", bus.rf_wdata); end
        checks++; if (prio_b !== 1'b1) begin errors++; $display("FAIL a_only_prio got %b exp 1", prio_b); end
        tick();
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL a_only_we_after got %b exp 0", bus.rf_we); end
        checks++; if (bus.rf_rd !== 5'd5) begin errors++; $display("FAIL a_only_rd_kept got %0d exp 5", bus.rf_rd); end
    endtask

    task automatic test_both_after_reset();
        apply_reset();
        bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'hA;
        bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'hB;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL both_a_ready got %b exp 1", bus.a_ready); end
        checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL both_b_ready got %b exp 0", bus.b_ready); end
        tick();
        bus.a_valid = 1'b0;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd3 || bus.rf_wdata !== 32'hA) begin
            errors++; $display("FAIL both_first we=%b rd=%0d data=%h exp we=1 rd=3 data=a", bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        checks++; if (prio_b !== 1'b1) begin errors++; $display("FAIL both_prio got %b exp 1", prio_b); end
        tick();
        bus.b_valid = 1'b0;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_wdata !== 32'hB) begin
            errors++; $display("FAIL both_second we=%b rd=%0d data=%h exp we=1 rd=7 data=b", bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        checks++; if (conflict_cnt !== 8'd1) begin errors++; $display("FAIL both_cnt got %0d exp 1", conflict_cnt); end
        checks++; if (prio_b !== 1'b0) begin errors++; $display("FAIL both_prio_end got %b exp 0", prio_b); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_rd   [6];
        logic [N-1:0]  exp_data [6];
        int ka = 0;
        int kb = 0;
        // A is granted on even cycles, B on odd; each presents a fresh payload after a grant
        exp_rd[0] = 5'd10; exp_data[0] = 32'hA000;
        exp_rd[1] = 5'd20; exp_data[1] = 32'hB000;
        exp_rd[2] = 5'd11; exp_data[2] = 32'hA001;
        exp_rd[3] = 5'd21; exp_data[3] = 32'hB001;
        exp_rd[4] = 5'd12; exp_data[4] = 32'hA002;
        exp_rd[5] = 5'd22; exp_data[5] = 32'hB002;
        apply_reset();
        bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = 32'hA000;
        bus.b_valid = 1'b1; bus.b_rd = 5'd20; bus.b_data = 32'hB000;
        for (int i = 0; i < 6; i++) begin
            tick();
            if ((i % 2) == 0) begin
                ka++;
                bus.a_rd   = AW'(10 + ka);
                bus.a_data = 32'hA000 + N'(ka);
            end else begin
                kb++;
                bus.b_rd   = AW'(20 + kb);
                bus.b_data = 32'hB000 + N'(kb);
            end
            checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== exp_rd[i] || bus.rf_wdata !== exp_data[i]) begin
                errors++; $display("FAIL b2b_%0d rd=%0d data=%h exp rd=%0d data=%h", i, bus.rf_rd, bus.rf_wdata, exp_rd[i], exp_data[i]);
            end
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        checks++; if (conflict_cnt !== 8'd6) begin errors++; $display("FAIL b2b_cnt got %0d exp 6", conflict_cnt); end
    endtask

    task automatic test_x0_and_same_rd();
        checks++; if (prio_b !== 1'b0) begin errors++; $display("FAIL x0_prio_before got %b exp 0", prio_b); end
        bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'hFFFF;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", bus.a_ready); end
        tick();
        bus.a_valid = 1'b0;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b exp 0", bus.rf_we); end
        checks++; if (prio_b !== 1'b1) begin errors++; $display("FAIL x0_prio got %b exp 1", prio_b); end

        apply_reset();
        bus.a_valid = 1'b1; bus.a_rd = 5'd9; bus.a_data = 32'h1;
        bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h2;
        tick();
        bus.a_valid = 1'b0;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd9 || bus.rf_wdata !== 32'h1) begin
            errors++; $display("FAIL same_rd_first we=%b rd=%0d data=%h exp we=1 rd=9 data=1", bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        tick();
        bus.b_valid = 1'b0;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd9 || bus.rf_wdata !== 32'h2) begin
            errors++; $display("FAIL same_rd_second we=%b rd=%0d data=%h exp we=1 rd=9 data=2", bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
    endtask

    task automatic test_hold_and_reset();
        // conflict_cnt is 1 and prio_b is 0 from the same-rd sequence
        hold = 1'b1;
        bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 32'h11;
        bus.b_valid = 1'b1; bus.b_rd = 5'd2; bus.b_data = 32'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
                errors++; $display("FAIL hold_ready_%0d a=%b b=%b exp 0 0", i, bus.a_ready, bus.b_ready);
            end
            tick();
            checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL hold_we_%0d got %b exp 0", i, bus.rf_we); end
            checks++; if (conflict_cnt !== 8'd1) begin errors++; $display("FAIL hold_cnt_%0d got %0d exp 1", i, conflict_cnt); end
            checks++; if (prio_b !== 1'b0) begin errors++; $display("FAIL hold_prio_%0d got %b exp 0", i, prio_b); end
        end
        hold = 1'b0;
        bus.b_valid = 1'b0;
        bus.a_rd = 5'd4; bus.a_data = 32'h55;
        tick();
        bus.a_valid = 1'b0;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd4) begin
            errors++; $display("FAIL pre_rst_write we=%b rd=%0d exp we=1 rd=4", bus.rf_we, bus.rf_rd);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL async_rst_we got %b exp 0", bus.rf_we); end
        checks++; if (bus.rf_rd !== 5'd0 || conflict_cnt !== 8'd0) begin
            errors++; $display("FAIL async_rst_state rd=%0d cnt=%0d exp 0 0", bus.rf_rd, conflict_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        bus.a_valid = 1'b1; bus.a_rd = 5'd6; bus.a_data = 32'h66;
        bus.b_valid = 1'b1; bus.b_rd = 5'd8; bus.b_data = 32'h88;
        for (int i = 0; i < 254; i++) tick();
        checks++; if (conflict_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", conflict_cnt); end
        tick();
        checks++; if (conflict_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", conflict_cnt); end
        for (int i = 0; i < 20; i++) tick();
        checks++; if (conflict_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", conflict_cnt); end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_a_only();
        test_both_after_reset();
        test_back_to_back();
        test_x0_and_same_rd();
        test_hold_and_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
